// File: rtl/maxnet_controller.sv
// rtl/maxnet_controller.sv - MaxNet iteration sequencer driving four process units
// Optional iteration cap: define MAXNET_ITER_LIMIT_EN to stop after MAX_ITER iterations with timeout set.
module maxnet_controller #(
   parameter int DATA_W   = 32,
   parameter int ITER_W   = 8,
   parameter int MAX_ITER = 200
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_in0,
   input  logic [DATA_W-1:0] i_in1,
   input  logic [DATA_W-1:0] i_in2,
   input  logic [DATA_W-1:0] i_in3,
   input  logic [DATA_W-1:0] i_pu_out0,
   input  logic [DATA_W-1:0] i_pu_out1,
   input  logic [DATA_W-1:0] i_pu_out2,
   input  logic [DATA_W-1:0] i_pu_out3,
   input  logic              i_pu_zero0,
   input  logic              i_pu_zero1,
   input  logic              i_pu_zero2,
   input  logic              i_pu_zero3,
   output logic [DATA_W-1:0] o_x0,
   output logic [DATA_W-1:0] o_x1,
   output logic [DATA_W-1:0] o_x2,
   output logic [DATA_W-1:0] o_x3,
   output logic              o_mw,
   output logic              o_aw,
   output logic              o_busy,
   output logic              o_done,
   output logic [1:0]        o_winner,
   output logic [DATA_W-1:0] o_winner_val,
   output logic              o_none_left,
   output logic [ITER_W-1:0] o_iter,
   output logic              o_timeout
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_MULT  = 3'd1;
   localparam logic [2:0] S_ADD   = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

`ifdef MAXNET_ITER_LIMIT_EN
   localparam logic LP_LIMIT_EN = 1'b1;
`else
   localparam logic LP_LIMIT_EN = 1'b0;
`endif

   logic [2:0]        r_state;
   logic [DATA_W-1:0] r_x [4];
   logic              r_busy;
   logic              r_done;
   logic [1:0]        r_winner;
   logic [DATA_W-1:0] r_winner_val;
   logic              r_none_left;
   logic [ITER_W-1:0] r_iter;
   logic              r_timeout;

   logic [DATA_W-1:0] w_pu_out [4];
   logic [3:0]        w_zero;
   logic [2:0]        w_nz;
   logic [1:0]        w_lead;
   logic [DATA_W-1:0] w_lead_val;
   logic [ITER_W:0]   w_iter_inc1;
   logic [ITER_W-1:0] w_iter_next;
   logic              w_cap_hit;
   logic              w_accept;
   logic              w_continue;

   always_comb begin
      w_pu_out[0] = i_pu_out0;
      w_pu_out[1] = i_pu_out1;
      w_pu_out[2] = i_pu_out2;
      w_pu_out[3] = i_pu_out3;
      w_zero      = {i_pu_zero3, i_pu_zero2, i_pu_zero1, i_pu_zero0};
      w_nz        = 3'd0;
      for (int i = 0; i < 4; i++) begin
         w_nz = w_nz + {2'b00, ~w_zero[i]};
      end
      // Scan downwards so the lowest surviving index wins.
      w_lead = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!w_zero[i]) w_lead = 2'(i);
      end
      w_lead_val = w_pu_out[w_lead];
   end

   assign w_iter_inc1 = {1'b0, r_iter} + {{ITER_W{1'b0}}, 1'b1};
   assign w_iter_next = (&r_iter) ? r_iter : w_iter_inc1[ITER_W-1:0];
   assign w_cap_hit   = LP_LIMIT_EN && (w_nz >= 3'd2) &&
                        (w_iter_inc1 == (ITER_W+1)'(MAX_ITER));
   assign w_continue  = (w_nz >= 3'd2) && !w_cap_hit;
   assign w_accept    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         for (int i = 0; i < 4; i++) r_x[i] <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_winner     <= 2'd0;
         r_winner_val <= '0;
         r_none_left  <= 1'b0;
         r_iter       <= '0;
         r_timeout    <= 1'b0;
      end else if (w_accept) begin
         r_state     <= S_MULT;
         r_x[0]      <= i_in0;
         r_x[1]      <= i_in1;
         r_x[2]      <= i_in2;
         r_x[3]      <= i_in3;
         r_iter      <= '0;
         r_busy      <= 1'b1;
         r_done      <= 1'b0;
         r_none_left <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         case (r_state)
            S_MULT:  r_state <= S_ADD;
            S_ADD:   r_state <= S_CHECK;
            S_CHECK: begin
               r_iter <= w_iter_next;
               if (w_continue) begin
                  for (int i = 0; i < 4; i++) r_x[i] <= w_pu_out[i];
                  r_state <= S_MULT;
               end else begin
                  r_state      <= S_DONE;
                  r_winner     <= w_lead;
                  r_winner_val <= (w_nz == 3'd0) ? '0 : w_lead_val;
                  r_none_left  <= (w_nz == 3'd0);
                  r_timeout    <= w_cap_hit;
                  r_busy       <= 1'b0;
                  r_done       <= 1'b1;
               end
            end
            S_IDLE, S_DONE: r_state <= r_state;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The strobes decode state directly so each is exactly one cycle and never overlaps.
   assign o_mw         = (r_state == S_MULT);
   assign o_aw         = (r_state == S_ADD);
   assign o_x0         = r_x[0];
   assign o_x1         = r_x[1];
   assign o_x2         = r_x[2];
   assign o_x3         = r_x[3];
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_winner     = r_winner;
   assign o_winner_val = r_winner_val;
   assign o_none_left  = r_none_left;
   assign o_iter       = r_iter;
   assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_maxnet_controller.sv
// tb/tb_maxnet_controller.sv - randomized scoreboard bench for maxnet_controller
// Acts as the four process units; MAXNET_ITER_LIMIT_EN selects the capped-run expectations.
module tb_maxnet_controller;

`ifdef MAXNET_ITER_LIMIT_EN
   localparam int CAP = 3;
`else
   localparam int CAP = 0;
`endif

   typedef struct packed {
      logic [3:0]   zero;
      logic [127:0] outs;
   } pat_t;

   typedef struct packed {
      logic [7:0]   iter;
      logic [127:0] x;
   } xexp_t;

   typedef struct packed {
      logic [1:0]  winner;
      logic [31:0] val;
      logic        none;
      logic        tmo;
      logic [7:0]  iter;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] in0, in1, in2, in3;
   logic [31:0] pu_out0, pu_out1, pu_out2, pu_out3;
   logic        pu_zero0, pu_zero1, pu_zero2, pu_zero3;
   logic [31:0] x0, x1, x2, x3;
   logic        mw, aw, busy, done, none_left, timeout;
   logic [1:0]  winner;
   logic [31:0] winner_val;
   logic [7:0]  iter;

   int total = 0;
   int bad   = 0;
   bit free_run = 1'b0;
   int cnt = 0;
   logic prev_mw = 1'b0, prev_aw = 1'b0, prev_done = 1'b0, prev_busy = 1'b0;

   pat_t  pat_q[$];
   pat_t  cur_pats[$];
   xexp_t xq[$];
   res_t  res_q[$];

   always #5 clk = ~clk;

   maxnet_controller #(.DATA_W(32), .ITER_W(8), .MAX_ITER(3)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .i_in0(in0), .i_in1(in1), .i_in2(in2), .i_in3(in3),
      .i_pu_out0(pu_out0), .i_pu_out1(pu_out1), .i_pu_out2(pu_out2), .i_pu_out3(pu_out3),
      .i_pu_zero0(pu_zero0), .i_pu_zero1(pu_zero1), .i_pu_zero2(pu_zero2), .i_pu_zero3(pu_zero3),
      .o_x0(x0), .o_x1(x1), .o_x2(x2), .o_x3(x3),
      .o_mw(mw), .o_aw(aw), .o_busy(busy), .o_done(done),
      .o_winner(winner), .o_winner_val(winner_val), .o_none_left(none_left),
      .o_iter(iter), .o_timeout(timeout)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: iterate the MaxNet rules over the scripted unit responses.
   task automatic model_run(input logic [127:0] in_vec);
      logic [127:0] xv;
      pat_t  p;
      res_t  r;
      int    nz;
      xv = in_vec;
      for (int k = 0; k < cur_pats.size(); k++) begin
         p = cur_pats[k];
         xq.push_back('{iter: 8'(k), x: xv});
         pat_q.push_back(p);
         nz = 4 - $countones(p.zero);
         if (nz >= 2 && !(CAP != 0 && k + 1 == CAP)) begin
            xv = p.outs;
         end else begin
            r.winner = 2'd0;
            for (int i = 3; i >= 0; i--) if (!p.zero[i]) r.winner = 2'(i);
            r.val  = (nz == 0) ? 32'd0 : p.outs[r.winner*32 +: 32];
            r.none = (nz == 0);
            r.tmo  = (nz >= 2);
            r.iter = 8'(k + 1);
            res_q.push_back(r);
            break;
         end
      end
      cur_pats.delete();
   endtask

   function automatic pat_t rand_pat(input bit last);
      pat_t p;
      p.outs = {$urandom, $urandom, $urandom, $urandom};
      if (!last) begin
         do p.zero = 4'($urandom_range(0, 15)); while ($countones(p.zero) > 2);
      end else if ($urandom_range(0, 2) == 0) begin
         p.zero = 4'hF;
      end else begin
         p.zero = ~(4'b0001 << $urandom_range(0, 3));
      end
      return p;
   endfunction

   task automatic set_in(input logic [127:0] v);
      in0 = v[31:0];
      in1 = v[63:32];
      in2 = v[95:64];
      in3 = v[127:96];
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400 && !done; i++) @(negedge clk);
      chk("wait_done_bound", {127'd0, done}, 128'd1);
   endtask

   task automatic run_single(input logic [127:0] v);
      model_run(v);
      set_in(v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
   endtask

   // Unit model: present the next scripted response during the cycle after aw.
   always @(negedge clk) begin : unit_drv
      pat_t p;
      if (aw) begin
         if (pat_q.size() > 0) p = pat_q.pop_front();
         else p = '{zero: 4'b1100, outs: {$urandom, $urandom, $urandom, $urandom}};
         {pu_zero3, pu_zero2, pu_zero1, pu_zero0} = p.zero;
         {pu_out3, pu_out2, pu_out1, pu_out0} = p.outs;
      end
   end

   always @(negedge clk) begin : monitor
      xexp_t xe;
      res_t  re;
      if (rst) begin
         prev_mw = 1'b0; prev_aw = 1'b0; prev_done = 1'b0; prev_busy = 1'b0; cnt = 0;
      end else begin
         chk("strobe_onehot_width", {125'd0, mw && aw, mw && prev_mw, aw && prev_aw}, 128'd0);
         if (busy && !prev_busy) cnt = 1;
         else cnt++;
         if (mw && !free_run) begin
            if (xq.size() == 0) begin
               chk("unexpected_mw", 128'd1, 128'd0);
            end else begin
               xe = xq.pop_front();
               chk("x_vector", {x3, x2, x1, x0}, xe.x);
               chk("iter_at_mw", {120'd0, iter}, {120'd0, xe.iter});
            end
         end
         if (done && !prev_done) begin
            if (res_q.size() == 0) begin
               chk("unexpected_done", 128'd1, 128'd0);
            end else begin
               re = res_q.pop_front();
               chk("winner", {126'd0, winner}, {126'd0, re.winner});
               chk("winner_val", {96'd0, winner_val}, {96'd0, re.val});
               chk("none_left", {127'd0, none_left}, {127'd0, re.none});
               chk("timeout", {127'd0, timeout}, {127'd0, re.tmo});
               chk("iter_done", {120'd0, iter}, {120'd0, re.iter});
               chk("busy_at_done", {127'd0, busy}, 128'd0);
               chk("latency", 128'(cnt), 128'(3 * int'(re.iter) + 1));
            end
         end
         prev_mw = mw; prev_aw = aw; prev_done = done; prev_busy = busy;
      end
   end

   initial begin
      logic [127:0] va, vb;
      rst = 1'b1; start = 1'b0;
      set_in('0);
      {pu_out3, pu_out2, pu_out1, pu_out0} = '0;
      {pu_zero3, pu_zero2, pu_zero1, pu_zero0} = 4'hF;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {121'd0, mw, aw, busy, done, none_left, timeout, winner != 2'd0},
          128'd0);
      chk("rst_x", {x3, x2, x1, x0}, 128'd0);
      chk("rst_iter_val", {88'd0, iter, winner_val}, 128'd0);
      rst = 1'b0;
      @(negedge clk);

      // Reset during ADD, with start also high on the reset edge.
      free_run = 1'b1;
      set_in({$urandom, $urandom, $urandom, $urandom});
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10 && !aw; i++) @(negedge clk);
      chk("reach_add", {127'd0, aw}, 128'd1);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      chk("abort_ctrl", {124'd0, mw, aw, busy, done}, 128'd0);
      chk("abort_x_iter", {x3 | x2 | x1 | x0, 88'd0, iter}, 128'd0);
      rst = 1'b0; start = 1'b0; free_run = 1'b0;
      @(negedge clk);

      // Two-iteration directed run.
      cur_pats.push_back('{zero: 4'b1100, outs: {32'd0, 32'd0, 32'h3E800000, 32'h3F400000}});
      cur_pats.push_back('{zero: 4'b1110, outs: {32'd0, 32'd0, 32'd0, 32'h3F200000}});
      run_single({32'd0, 32'd0, 32'h3F000000, 32'h3F800000});
      chk("dir2_result", {86'd0, winner, winner_val, iter}, {86'd0, 2'd0, 32'h3F200000, 8'd2});

      // All units zero on the first check.
      cur_pats.push_back('{zero: 4'b1111, outs: {$urandom, $urandom, $urandom, $urandom}});
      run_single({$urandom, $urandom, $urandom, $urandom});
      chk("dir3_result", {85'd0, none_left, winner, winner_val, iter}, {85'd0, 1'b1, 2'd0, 32'd0, 8'd1});

      for (int r = 0; r < 20; r++) begin
         int n;
         if (r % 5 == 4) begin
            // Start held high: ignored while busy, restarts from DONE with the new inputs.
            va = {$urandom, $urandom, $urandom, $urandom};
            vb = {$urandom, $urandom, $urandom, $urandom};
            n = $urandom_range(1, 4);
            for (int k = 0; k < n - 1; k++) cur_pats.push_back(rand_pat(1'b0));
            cur_pats.push_back(rand_pat(1'b1));
            model_run(va);
            n = $urandom_range(1, 4);
            for (int k = 0; k < n - 1; k++) cur_pats.push_back(rand_pat(1'b0));
            cur_pats.push_back(rand_pat(1'b1));
            model_run(vb);
            set_in(va);
            start = 1'b1;
            @(negedge clk);
            set_in(vb);
            wait_done();
            @(negedge clk);
            chk("restart_after_done", {126'd0, busy, done}, {126'd0, 1'b1, 1'b0});
            start = 1'b0;
            wait_done();
         end else begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n - 1; k++) cur_pats.push_back(rand_pat(1'b0));
            cur_pats.push_back(rand_pat(1'b1));
            run_single({$urandom, $urandom, $urandom, $urandom});
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

`ifdef MAXNET_ITER_LIMIT_EN
      for (int k = 0; k < 3; k++)
         cur_pats.push_back('{zero: 4'b1100, outs: {32'd0, 32'd0, $urandom, $urandom}});
      run_single({$urandom, $urandom, $urandom, $urandom});
      chk("cap_result", {116'd0, timeout, none_left, winner, iter}, {116'd0, 1'b1, 1'b0, 2'd0, 8'd3});
`else
      free_run = 1'b1;
      set_in({$urandom, $urandom, $urandom, $urandom});
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (110) @(negedge clk);
      chk("uncapped_still_busy", {126'd0, busy, done}, {126'd0, 1'b1, 1'b0});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; free_run = 1'b0;
`endif

      repeat (3) @(negedge clk);
      chk("queues_drained", 128'(xq.size() + res_q.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
